// File: rtl/uart_speed_receiver.sv
// Oversampled 8N1 UART receiver with a two-byte speed-frame depacketizer.
// Header byte {2'b11, hi bits} followed by the low byte rebuilds one speed value.
module uart_speed_receiver #(
    parameter int SYS_FREQ     = 10000000,
    parameter int BAUD_RATE    = 9600,
    parameter int SAMPLE       = 16,
    parameter int BAUD_DVSR    = SYS_FREQ / (SAMPLE * BAUD_RATE),
    parameter int DATA_SIZE    = 8,
    parameter int WIDTH_SPEED  = 14,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   serial_data_in,
    output logic [DATA_SIZE-1:0]   rx_data,
    output logic                   rx_valid,
    output logic                   frame_error,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   speed_valid,
    output logic                   sync_error
);
    localparam int DW       = $clog2(BAUD_DVSR + 1);
    localparam int TW       = $clog2(SAMPLE);
    localparam int BW       = $clog2(DATA_SIZE);
    localparam int HI_W     = WIDTH_SPEED - DATA_SIZE;
    localparam int TO_TICKS = TIMEOUT_BITS * SAMPLE;
    localparam int TOW      = $clog2(TO_TICKS + 1);

    typedef enum logic [2:0] {L_IDLE, L_START, L_DATA, L_STOP, L_BREAK} line_st_t;
    typedef enum logic {F_WAIT_HDR, F_WAIT_LO} frame_st_t;

    logic                 r_sync1, r_sync2;
    logic [DW-1:0]        r_baud_cnt;
    line_st_t             r_line_st;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_SIZE-1:0] r_shift;
    logic [DATA_SIZE-1:0] r_rx_data;
    logic                 r_rx_valid, r_frame_error;
    frame_st_t            r_frame_st;
    logic [HI_W-1:0]      r_hi;
    logic [TOW-1:0]       r_to_cnt;
    logic [WIDTH_SPEED-1:0] r_speed;
    logic                 r_speed_valid, r_sync_error;

    logic w_rx, w_tick, w_start, w_half, w_last;

    assign w_rx    = r_sync2;
    assign w_tick  = (r_baud_cnt == DW'(BAUD_DVSR - 1));
    assign w_start = (r_line_st == L_IDLE) && !w_rx;
    assign w_half  = (r_tick_cnt == TW'(SAMPLE / 2 - 1));
    assign w_last  = (r_tick_cnt == TW'(SAMPLE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_data_in;
            r_sync2 <= r_sync1;
        end
    end

    // Restarting on the start edge keeps the mid-bit sample phase aligned to the character.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_baud_cnt <= '0;
        else if (w_start || w_tick)  r_baud_cnt <= '0;
        else                         r_baud_cnt <= r_baud_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_st     <= L_IDLE;
            r_tick_cnt    <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_line_st)
                L_IDLE: if (!w_rx) begin
                    r_line_st  <= L_START;
                    r_tick_cnt <= '0;
                end
                L_START: if (w_tick) begin
                    if (w_half) begin
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_line_st  <= w_rx ? L_IDLE : L_DATA;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                L_DATA: if (w_tick) begin
                    if (w_last) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rx, r_shift[DATA_SIZE-1:1]};
                        if (r_bit_idx == BW'(DATA_SIZE - 1)) r_line_st <= L_STOP;
                        else                                 r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                L_STOP: if (w_tick) begin
                    if (w_last) begin
                        r_tick_cnt <= '0;
                        if (w_rx) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_line_st  <= L_IDLE;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_line_st     <= L_BREAK;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                L_BREAK: if (w_rx) r_line_st <= L_IDLE;
                default: r_line_st <= L_IDLE;
            endcase
        end
    end

    // A byte arriving in the same clk as the timeout takes priority over the drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_st    <= F_WAIT_HDR;
            r_hi          <= '0;
            r_to_cnt      <= '0;
            r_speed       <= '0;
            r_speed_valid <= 1'b0;
            r_sync_error  <= 1'b0;
        end else begin
            r_speed_valid <= 1'b0;
            r_sync_error  <= 1'b0;
            case (r_frame_st)
                F_WAIT_HDR: if (r_rx_valid && (r_rx_data[DATA_SIZE-1 -: 2] == 2'b11)) begin
                    r_hi       <= r_rx_data[HI_W-1:0];
                    r_to_cnt   <= '0;
                    r_frame_st <= F_WAIT_LO;
                end
                F_WAIT_LO: begin
                    if (r_rx_valid) begin
                        r_speed       <= {r_hi, r_rx_data};
                        r_speed_valid <= 1'b1;
                        r_frame_st    <= F_WAIT_HDR;
                    end else if (r_frame_error ||
                                 (w_tick && (r_to_cnt == TOW'(TO_TICKS - 1)))) begin
                        r_sync_error <= 1'b1;
                        r_frame_st   <= F_WAIT_HDR;
                    end else if (w_tick) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_frame_st <= F_WAIT_HDR;
            endcase
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;
    assign speed       = r_speed;
    assign speed_valid = r_speed_valid;
    assign sync_error  = r_sync_error;
endmodule

// File: tb/tb_uart_speed_receiver.sv
// Directed bench for uart_speed_receiver at a fast baud (10 clk per tick) to keep runtime short.
module tb_uart_speed_receiver;
    localparam int DVSR    = 10;
    localparam int BIT_CLK = DVSR * 16;
    // start edge -> rx_valid: 2 sync flops + 1 registered output + 152 ticks
    localparam int RX_LAT  = 152 * DVSR + 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        si = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_error, speed_valid, sync_error;
    logic [13:0] speed;

    int cyc = 0, start_cyc = 0, rxv_cyc = 0, spv_cyc = 0;
    int n_rxv = 0, n_fe = 0, n_spv = 0, n_se = 0;
    int n_checks = 0, n_fail = 0;

    uart_speed_receiver #(.SYS_FREQ(10000000), .BAUD_RATE(62500)) dut (
        .clk(clk), .reset_n(reset_n), .serial_data_in(si),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
        .speed(speed), .speed_valid(speed_valid), .sync_error(sync_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid)    begin n_rxv++; rxv_cyc = cyc; end
        if (frame_error) n_fe++;
        if (speed_valid) begin n_spv++; spv_cyc = cyc; end
        if (sync_error)  n_se++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        si = 1'b0;
        start_cyc = cyc;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            si = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        si = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [26:0] outs;
        repeat (5) @(negedge clk);
        outs = {rx_data, rx_valid, frame_error, speed, speed_valid, sync_error};
        n_checks++;
        if (outs !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
    endtask

    task automatic test_single_byte();
        send_byte(8'hA5, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        n_checks++;
        if (n_rxv !== 1) begin n_fail++; $display("FAIL a5_count: got %0d expected 1", n_rxv); end
        n_checks++;
        if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h expected a5", rx_data); end
        n_checks++;
        if (rxv_cyc - start_cyc !== RX_LAT) begin
            n_fail++; $display("FAIL a5_latency: got %0d expected %0d", rxv_cyc - start_cyc, RX_LAT);
        end
        n_checks++;
        if (n_fe + n_spv + n_se !== 0) begin
            n_fail++; $display("FAIL a5_no_pulses: fe %0d spv %0d se %0d expected all 0", n_fe, n_spv, n_se);
        end
    endtask

    task automatic test_speed_frames();
        send_byte(8'hD2, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        n_checks++;
        if (speed !== 14'h1234) begin n_fail++; $display("FAIL speed_1234: got %h expected 1234", speed); end
        n_checks++;
        if (n_spv !== 1) begin n_fail++; $display("FAIL spv_count1: got %0d expected 1", n_spv); end
        n_checks++;
        if (spv_cyc !== rxv_cyc + 1) begin
            n_fail++; $display("FAIL spv_latency: got %0d expected %0d", spv_cyc, rxv_cyc + 1);
        end
        send_byte(8'hFF, 1'b1);
        send_byte(8'hC7, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        n_checks++;
        if (speed !== 14'h3FC7) begin n_fail++; $display("FAIL speed_3fc7: got %h expected 3fc7", speed); end
        n_checks++;
        if (n_spv !== 2) begin n_fail++; $display("FAIL spv_count2: got %0d expected 2", n_spv); end
        n_checks++;
        if (n_se !== 0) begin n_fail++; $display("FAIL frames_no_sync: got %0d expected 0", n_se); end
    endtask

    task automatic test_glitch();
        int rxv0, fe0;
        rxv0 = n_rxv; fe0 = n_fe;
        @(negedge clk);
        si = 1'b0;
        repeat (3 * DVSR) @(negedge clk);
        si = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        n_checks++;
        if (n_rxv !== rxv0 || n_fe !== fe0) begin
            n_fail++; $display("FAIL glitch_ignored: rxv %0d fe %0d expected %0d %0d", n_rxv, n_fe, rxv0, fe0);
        end
        send_byte(8'h3C, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        n_checks++;
        if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_next: got %h expected 3c", rx_data); end
        n_checks++;
        if (n_rxv !== rxv0 + 1) begin n_fail++; $display("FAIL glitch_count: got %0d expected %0d", n_rxv, rxv0 + 1); end
    endtask

    task automatic test_frame_error();
        int rxv0, fe0, se0;
        rxv0 = n_rxv; fe0 = n_fe; se0 = n_se;
        send_byte(8'h55, 1'b0);
        repeat (3 * BIT_CLK) @(negedge clk);
        si = 1'b1;
        repeat (12 * BIT_CLK) @(negedge clk);
        n_checks++;
        if (n_fe !== fe0 + 1) begin n_fail++; $display("FAIL fe_count: got %0d expected %0d", n_fe, fe0 + 1); end
        n_checks++;
        if (n_rxv !== rxv0 || rx_data !== 8'h3C) begin
            n_fail++; $display("FAIL fe_data_held: rxv %0d data %h expected %0d 3c", n_rxv, rx_data, rxv0);
        end
        n_checks++;
        if (n_se !== se0) begin n_fail++; $display("FAIL fe_no_sync: got %0d expected %0d", n_se, se0); end
    endtask

    task automatic test_timeout();
        int spv0, se0;
        spv0 = n_spv; se0 = n_se;
        send_byte(8'hC1, 1'b1);
        repeat (21 * BIT_CLK) @(negedge clk);
        n_checks++;
        if (n_se !== se0 + 1) begin n_fail++; $display("FAIL to_sync: got %0d expected %0d", n_se, se0 + 1); end
        n_checks++;
        if (n_spv !== spv0) begin n_fail++; $display("FAIL to_no_speed: got %0d expected %0d", n_spv, spv0); end
        send_byte(8'hC0, 1'b1);
        send_byte(8'h07, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        n_checks++;
        if (speed !== 14'h0007) begin n_fail++; $display("FAIL to_speed_0007: got %h expected 0007", speed); end
        n_checks++;
        if (n_spv !== spv0 + 1) begin n_fail++; $display("FAIL to_spv: got %0d expected %0d", n_spv, spv0 + 1); end
        n_checks++;
        if (n_se !== se0 + 1) begin n_fail++; $display("FAIL to_sync_once: got %0d expected %0d", n_se, se0 + 1); end
    endtask

    task automatic test_reset_mid_frame();
        int spv0, se0, fe0;
        logic [7:0]  part;
        logic [26:0] outs;
        part = 8'h5A;
        send_byte(8'hC0, 1'b1);
        @(negedge clk);
        si = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            si = part[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        si = 1'b1;
        outs = {rx_data, rx_valid, frame_error, speed, speed_valid, sync_error};
        n_checks++;
        if (outs !== 27'd0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
        repeat (BIT_CLK) @(negedge clk);
        reset_n = 1'b1;
        spv0 = n_spv; se0 = n_se; fe0 = n_fe;
        repeat (2 * BIT_CLK) @(negedge clk);
        send_byte(8'hC0, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (BIT_CLK) @(negedge clk);
        n_checks++;
        if (speed !== 14'h0010) begin n_fail++; $display("FAIL midreset_speed: got %h expected 0010", speed); end
        n_checks++;
        if (n_spv !== spv0 + 1) begin n_fail++; $display("FAIL midreset_spv: got %0d expected %0d", n_spv, spv0 + 1); end
        n_checks++;
        if (n_se !== se0 || n_fe !== fe0) begin
            n_fail++; $display("FAIL midreset_no_err: se %0d fe %0d expected %0d %0d", n_se, n_fe, se0, fe0);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_speed_frames();
        test_glitch();
        test_frame_error();
        test_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_speed_receiver.md
Name: uart_speed_receiver

Overview:
- Receive end of the roadside speed-report UART link: oversampled 8N1 receiver plus frame depacketizer that rebuilds a WIDTH_SPEED-bit speed value from the two-byte frame produced by the transmit side.
- Sits at the logging/display unit and takes the serial_data_out wire of the ETC board as its serial input.
- Outputs each received byte and each completed speed value, plus error pulses.

Parameters:
- SYS_FREQ, 10000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- SAMPLE, 16, oversampling ticks per bit.
- BAUD_DVSR, SYS_FREQ/(SAMPLE*BAUD_RATE), clk cycles per sample tick; integer division, so the default is 65.
- DATA_SIZE, 8, data bits per UART character.
- WIDTH_SPEED, 14, speed width; must be at most 2*DATA_SIZE-2.
- TIMEOUT_BITS, 20, number of bit times allowed between the header byte and the low byte.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- serial_data_in  input  1  UART line; idles high; asynchronous to clk.
- rx_data  output  DATA_SIZE  last correctly framed byte.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- frame_error  output  1  one-clk pulse when the stop bit samples 0.
- speed  output  WIDTH_SPEED  last reassembled speed.
- speed_valid  output  1  one-clk pulse when speed updates.
- sync_error  output  1  one-clk pulse when a partial frame is dropped.

Behaviour:
- Reset: one clock, clk; reset_n is asynchronous and active-low. While reset_n=0, every output is 0, the synchronizer is preset to 1, the line FSM is in IDLE and the frame FSM is in WAIT_HDR. Asserting reset mid-character or mid-frame discards the partial data with no pulses.
- Input path: 2-flop synchronizer on serial_data_in. All decisions use the synchronized value.
- Tick generator: free-running counter 0..BAUD_DVSR-1 producing a one-clk tick. It restarts at 0 on each IDLE to START transition.
- Line FSM, with a 4-bit tick count and a 3-bit bit index:
  - IDLE: on synced 0, go to START with tick count cleared.
  - START: on tick count SAMPLE/2-1 (7), if the line is still 0, go to DATA with tick count cleared. If the line is 1, it was a glitch: return to IDLE with no output.
  - DATA: every SAMPLE ticks, sample one bit and shift it in LSB first. After DATA_SIZE bits, go to STOP.
  - STOP: after SAMPLE ticks, sample the line. If it is 1, load rx_data, pulse rx_valid in the next clk, and go to IDLE. If it is 0, pulse frame_error, leave rx_data unchanged, and go to BREAK.
  - BREAK: wait for synced 1, then go to IDLE. A line held low re-arms only after it returns high.
- rx_valid latency: rx_valid is asserted 1 clk after the stop-bit mid-sample, about 9.5 bit times after the start edge.
- Frame format, transmit-side contract:
  - Header byte = {2'b11, speed[13:8]}.
  - Low byte = speed[7:0].
  - Generic form: the header carries the upper WIDTH_SPEED-DATA_SIZE bits, zero-extended beneath the 2'b11 marker.
- Frame FSM, driven by rx_valid and frame_error:
  - WAIT_HDR: a byte with [7:6]==2'b11 latches the high bits and moves to WAIT_LO. Any other byte is ignored with no error.
  - WAIT_LO: the next rx_valid byte is taken as the low byte unconditionally, even if its top bits are 11. Then speed = {hi, byte}, speed_valid pulses 1 clk after that rx_valid, and the FSM returns to WAIT_HDR.
- Drop conditions in WAIT_LO, each pulses sync_error once and returns to WAIT_HDR:
  - frame_error.
  - Timeout: TIMEOUT_BITS*SAMPLE ticks elapse after the header's rx_valid with no new byte.
- Simultaneous events: a timeout expiring in the same clk as the low byte's rx_valid completes the frame; the byte wins.
- speed and rx_data hold their values until the next update.
- There is no back-pressure. A consumer must capture on the valid pulse.

Test Plan:
- Send byte 0xA5 at 9600 baud -> rx_valid pulses once, rx_data=0xA5, about 9.5 bit times (about 9880 clk) after the start edge; no other pulses.
- Send 0xD2 then 0x34 -> speed=0x1234 with a speed_valid pulse 1 clk after the second rx_valid; then 0xFF, 0xC7 -> speed=0x3FC7, proving a low byte with a 11 prefix is accepted.
- Low glitch of 3 ticks (195 clk) on an idle line -> no rx_valid, no frame_error; a following 0x3C is received correctly.
- Send 0x55 with stop bit forced 0 and the line then held low for 3 bit times -> frame_error pulses once, rx_data is unchanged, and no further start is detected until the line returns high.
- Send header 0xC1 then silence for 21 bit times -> sync_error pulses once with no speed_valid; a following 0xC0, 0x07 -> speed=0x0007.
- Assert reset_n=0 mid DATA bits of the low byte, then release and send 0xC0, 0x10 -> all outputs are 0 during reset; after release speed=0x0010 with no sync_error.
